// File: rtl/wbm_seq_pkg.sv
// Shared encodings for the Wishbone pattern sequencer: command opcodes,
// FSM states and parameter defaults.
package wbm_seq_pkg;

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int ADDR_STEP_DEF   = 4;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,   // write seed + i to every beat
        OP_READ  = 2'd1,   // read every beat onto the rd_* stream
        OP_CHECK = 2'd2,   // write the pattern, then read back and compare
        OP_RSVD  = 2'd3    // behaves exactly like OP_READ
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WGAP,
        S_RD,
        S_RGAP,
        S_FIN
    } state_e;

    // Only fill and check commands start with a write pass.
    function automatic logic op_writes(input logic [1:0] op);
        return (op == OP_FILL) || (op == OP_CHECK);
    endfunction

endpackage

// File: rtl/wbm_seq_timeout.sv
// Per-beat watchdog. start_i is high while a beat strobes, and the count
// clears whenever it is low, so every new strobe starts again from zero.
// expired_o flags the last strobe cycle allowed without an ack.
module wbm_seq_timeout
    import wbm_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count strobe cycles without an ack and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!start_i) begin
            cnt_d = '0;
        end else if (!ack_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the final allowed cycle still completes the beat.
    assign expired_o = start_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/wbm_seq.sv
// Wishbone master that runs one pattern command at a time: fill a range
// with seed + i, read a range out, or fill and read back, counting
// mismatches. Each beat is followed by a one-cycle strobe gap.
module wbm_seq
    import wbm_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ADDR_STEP   = ADDR_STEP_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] cmd_seed,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic [7:0]  err_cnt,
    output logic        timeout
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] adr_q, adr_d;
    logic        rb_q, rb_d;        // write pass finished, now reading back
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [7:0]  err_q, err_d;
    logic        to_q, to_d;

    logic        expired;
    logic        last_beat;
    logic [31:0] pattern;

    assign last_beat = ((beat_q + 8'd1) == len_q);
    assign pattern   = seed_q + {24'd0, beat_q};

    wbm_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_n_i   (wb_rst_n_i),
        .start_i   (wbm_stb_o),
        .ack_i     (wbm_ack_i),
        .expired_o (expired)
    );

    // Next-state logic: command capture, beat sequencing and status updates.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        len_d      = len_q;
        seed_d     = seed_q;
        beat_d     = beat_q;
        adr_d      = adr_q;
        rb_d       = rb_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        to_d       = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    base_d = cmd_addr;
                    len_d  = cmd_len;
                    seed_d = cmd_seed;
                    adr_d  = cmd_addr;
                    beat_d = 8'd0;
                    rb_d   = 1'b0;
                    err_d  = 8'd0;
                    to_d   = 1'b0;
                    if (cmd_len == 8'd0)         state_d = S_FIN;
                    else if (op_writes(cmd_op)) state_d = S_WR;
                    else                        state_d = S_RD;
                end
            end
            S_WR: begin
                if (wbm_ack_i) begin
                    state_d = S_WGAP;
                    if (!last_beat) begin
                        beat_d = beat_q + 8'd1;
                        adr_d  = adr_q + STEP;
                    end else if (op_q == OP_CHECK) begin
                        // Readback restarts at the first address and beat.
                        rb_d   = 1'b1;
                        beat_d = 8'd0;
                        adr_d  = base_q;
                    end else begin
                        state_d = S_FIN;
                    end
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_WGAP: state_d = rb_q ? S_RD : S_WR;
            S_RD: begin
                if (wbm_ack_i) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = wbm_dat_i;
                    if ((op_q == OP_CHECK) && (wbm_dat_i != pattern) && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    if (last_beat) begin
                        state_d = S_FIN;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        adr_d   = adr_q + STEP;
                        state_d = S_RGAP;
                    end
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_RGAP: state_d = S_RD;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            base_q     <= 32'd0;
            len_q      <= 8'd0;
            seed_q     <= 32'd0;
            beat_q     <= 8'd0;
            adr_q      <= 32'd0;
            rb_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            err_q      <= 8'd0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            len_q      <= len_d;
            seed_q     <= seed_d;
            beat_q     <= beat_d;
            adr_q      <= adr_d;
            rb_q       <= rb_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    // Bus controls decode straight from the state so reset clears them at once.
    assign cmd_ready = (state_q == S_IDLE);
    assign wbm_cyc_o = (state_q == S_WR) || (state_q == S_WGAP) ||
                       (state_q == S_RD) || (state_q == S_RGAP);
    assign wbm_stb_o = (state_q == S_WR) || (state_q == S_RD);
    assign wbm_we_o  = (state_q == S_WR) || (state_q == S_WGAP);
    assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = pattern;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = (state_q == S_FIN);
    assign err_cnt   = err_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_wbm_seq.sv
// Directed bench for wbm_seq with a memory-model Wishbone slave and
// scoreboard queues of expected writes and read data.
module tb_wbm_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [31:0] cmd_seed = 32'd0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic [7:0]  err_cnt;
    logic        timeout;

    always #5 clk = ~clk;

    wbm_seq #(.TIMEOUT_CYC(8), .ADDR_STEP(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_seed   (cmd_seed),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .done       (done),
        .err_cnt    (err_cnt),
        .timeout    (timeout)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [bit [31:0]];
    bit          ack_en = 1'b1;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_adr = 32'd0;
    int          gaps = 0;
    int          stb_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait slave with memory model, plus scoreboard pops.
    always @(negedge clk) begin
        logic [31:0] d;
        wr_t         w;
        wbm_ack_i = 1'b0;
        if (wbm_cyc_o && !wbm_stb_o) gaps++;
        if (wbm_stb_o) stb_cycles++;
        if (wbm_cyc_o && wbm_stb_o && ack_en) begin
            wbm_ack_i = 1'b1;
            chk("sel", {28'd0, wbm_sel_o}, 32'hF);
            if (wbm_we_o) begin
                mem[wbm_adr_o] = wbm_dat_o;
                chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    chk("wr_adr", wbm_adr_o, w.adr);
                    chk("wr_dat", wbm_dat_o, w.dat);
                end
            end else begin
                d = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'hDEADBEEF;
                if (corrupt_en && (wbm_adr_o == corrupt_adr)) d[0] = ~d[0];
                wbm_dat_i = d;
            end
        end
        if (rd_valid) begin
            chk("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) chk("rd_data", rd_data, rd_q.pop_front());
        end
    end

    task automatic push_writes(input logic [31:0] addr, input int len, input logic [31:0] seed);
        for (int i = 0; i < len; i++) begin
            wr_q.push_back('{adr: addr + 32'(4 * i), dat: seed + 32'(i)});
        end
    endtask

    // Drive one command and wait (bounded) for done; one extra cycle lets
    // the monitor drain the final read beat.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] seed, output int lat, output logic cyc1,
                           output logic [31:0] adr1);
        bit got;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; got = 1'b0; cyc1 = 1'b0; adr1 = 32'd0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cyc1 = wbm_cyc_o;
                adr1 = wbm_adr_o;
            end
            if (done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          g0;
        int          s0;
        int          seen;
        logic        cyc1;
        logic [31:0] adr1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;

        // Write-fill: four beats, gaps after the first three acks
        g0 = gaps;
        push_writes(32'h100, 4, 32'h10);
        run_cmd(2'd0, 32'h100, 8'd4, 32'h10, lat, cyc1, adr1);
        $display("fill: lat=%0d err=%0d", lat, err_cnt);
        chk("fill_cyc_t1", {31'd0, cyc1}, 32'd1);
        chk("fill_adr_t1", adr1, 32'h100);
        chk("fill_latency", lat, 32'd8);
        chk("fill_gaps", gaps - g0, 32'd3);
        chk("fill_wr_left", wr_q.size(), 32'd0);
        chk("fill_err", {24'd0, err_cnt}, 32'd0);

        // Write then readback, clean memory
        g0 = gaps;
        push_writes(32'h200, 3, 32'hA0);
        rd_q.push_back(32'hA0); rd_q.push_back(32'hA1); rd_q.push_back(32'hA2);
        run_cmd(2'd2, 32'h200, 8'd3, 32'hA0, lat, cyc1, adr1);
        $display("check: lat=%0d err=%0d", lat, err_cnt);
        chk("chk_latency", lat, 32'd12);
        chk("chk_gaps", gaps - g0, 32'd5);
        chk("chk_rd_left", rd_q.size(), 32'd0);
        chk("chk_err", {24'd0, err_cnt}, 32'd0);

        // Readback with bit 0 of beat 1 corrupted by the slave
        corrupt_en = 1'b1; corrupt_adr = 32'h304;
        push_writes(32'h300, 3, 32'hA0);
        rd_q.push_back(32'hA0); rd_q.push_back(32'hA0); rd_q.push_back(32'hA2);
        run_cmd(2'd2, 32'h300, 8'd3, 32'hA0, lat, cyc1, adr1);
        corrupt_en = 1'b0;
        $display("corrupt: lat=%0d err=%0d", lat, err_cnt);
        chk("corrupt_rd_left", rd_q.size(), 32'd0);
        chk("corrupt_err", {24'd0, err_cnt}, 32'd1);

        // Address wrap at the top of the space
        push_writes(32'hFFFFFFFC, 2, 32'h5);
        run_cmd(2'd0, 32'hFFFFFFFC, 8'd2, 32'h5, lat, cyc1, adr1);
        $display("wrap: lat=%0d", lat);
        chk("wrap_latency", lat, 32'd4);
        chk("wrap_wr_left", wr_q.size(), 32'd0);
        chk("wrap_err_cleared", {24'd0, err_cnt}, 32'd0);

        // Reserved opcode reads like op 1 (no compare)
        rd_q.push_back(32'h10); rd_q.push_back(32'h11);
        run_cmd(2'd3, 32'h100, 8'd2, 32'hFF, lat, cyc1, adr1);
        $display("op3 read: lat=%0d err=%0d", lat, err_cnt);
        chk("op3_latency", lat, 32'd4);
        chk("op3_rd_left", rd_q.size(), 32'd0);
        chk("op3_err", {24'd0, err_cnt}, 32'd0);

        // Timeout: slave stays silent
        ack_en = 1'b0;
        s0 = stb_cycles;
        run_cmd(2'd1, 32'h500, 8'd3, 32'h0, lat, cyc1, adr1);
        $display("timeout: lat=%0d stb=%0d to=%0d", lat, stb_cycles - s0, timeout);
        chk("to_latency", lat, 32'd9);
        chk("to_stb_cycles", stb_cycles - s0, 32'd8);
        chk("to_flag_held", {31'd0, timeout}, 32'd1);
        chk("to_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
        ack_en = 1'b1;

        // Zero-length command: done next cycle, no strobe, status cleared
        s0 = stb_cycles;
        run_cmd(2'd0, 32'h400, 8'd0, 32'h0, lat, cyc1, adr1);
        $display("len0: lat=%0d", lat);
        chk("len0_latency", lat, 32'd1);
        chk("len0_cyc_t1", {31'd0, cyc1}, 32'd0);
        chk("len0_no_stb", stb_cycles - s0, 32'd0);
        chk("len0_to_cleared", {31'd0, timeout}, 32'd0);
        chk("len0_err", {24'd0, err_cnt}, 32'd0);

        // Reset asserted in the middle of a beat
        ack_en = 1'b0;
        @(negedge clk);
        cmd_op = 2'd0; cmd_addr = 32'h600; cmd_len = 8'd2; cmd_seed = 32'h77;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midbeat_stb", {31'd0, wbm_stb_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("midrst_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("midrst_we", {31'd0, wbm_we_o}, 32'd0);
        chk("midrst_adr", wbm_adr_o, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbm_cyc_o) seen++;
        end
        chk("postrst_no_resume", seen, 32'd0);
        chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        push_writes(32'h700, 1, 32'h42);
        run_cmd(2'd0, 32'h700, 8'd1, 32'h42, lat, cyc1, adr1);
        $display("post-reset fill: lat=%0d", lat);
        chk("postrst_latency", lat, 32'd2);
        chk("postrst_wr_left", wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
